// File: rtl/upsampler_interp_100x.sv
// upsampler_interp_100x: RATIO-times upsampler with linear interpolation (UPSAMPLER_LINEAR_INTERP_EN) or zero-order hold
module upsampler_interp_100x #(
  parameter int DATA_W = 16,
  parameter int RATIO = 100,
  parameter int RECIP = 655,
  parameter int RECIP_SHIFT = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     s_valid,
  input  logic signed [DATA_W-1:0] s_data,
  input  logic                     err_clr,
  output logic                     m_valid,
  output logic signed [DATA_W-1:0] m_data,
  output logic                     err_early,
  output logic                     err_late
);
  typedef enum logic [1:0] {IDLE, PRIME, RUN, HOLD} state_t;
  localparam logic [7:0] LAST = 8'(RATIO - 1);
  state_t state, state_nx;
  logic [7:0] phase;
  logic last, early_ev, late_ev, v1;
  logic signed [DATA_W-1:0] prev, curr, base, y;
  assign last = phase == LAST;
  // next state and timing error events
  always_comb begin
    state_nx = state;
    early_ev = state == RUN && s_valid && !last;
    late_ev = state == RUN && !s_valid && last;
    if (s_valid) state_nx = state == IDLE ? PRIME : RUN;
    else if (late_ev) state_nx = HOLD;
  end
  // state, sample history, phase, sticky flags and output pipeline
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      phase <= '0;
      prev <= '0;
      curr <= '0;
      base <= '0;
      v1 <= 1'b0;
      m_valid <= 1'b0;
      m_data <= '0;
      err_early <= 1'b0;
      err_late <= 1'b0;
    end else begin
      state <= state_nx;
      phase <= s_valid ? '0 : last ? phase : phase + 8'd1;
      if (s_valid) begin
        prev <= curr;
        curr <= s_data;
      end
      err_early <= (err_early & ~err_clr) | early_ev;
      err_late <= (err_late & ~err_clr) | late_ev;
      base <= state == HOLD ? curr : prev;
      v1 <= state == RUN || state == HOLD;
      m_valid <= m_valid | v1;
      m_data <= y;
    end
  end
`ifdef UPSAMPLER_LINEAR_INTERP_EN
  localparam int PW = DATA_W + RECIP_SHIFT + 11;
  localparam logic signed [PW-1:0] HALF = PW'(2 ** (RECIP_SHIFT - 1));
  localparam logic signed [RECIP_SHIFT+1:0] RC = (RECIP_SHIFT + 2)'(RECIP);
  logic signed [DATA_W:0] delta;
  logic signed [DATA_W+8:0] acc;
  logic signed [DATA_W-1:0] frac;
  // segment slope, ramp accumulator and registered scaled offset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      delta <= '0;
      acc <= '0;
      frac <= '0;
    end else begin
      if (s_valid) begin
        delta <= (DATA_W + 1)'(s_data) - (DATA_W + 1)'(curr);
        acc <= '0;
      end else if (state == RUN && !last) acc <= acc + (DATA_W + 9)'(delta);
      frac <= state == HOLD ? '0 : DATA_W'((PW'(acc) * PW'(RC) + HALF) >>> RECIP_SHIFT);
    end
  end
  assign y = base + frac;
`else
  assign y = base;
`endif
endmodule

// File: tb/tb_upsampler_interp_100x.sv
// tb_upsampler_interp_100x: directed table and sequence checks for upsampler_interp_100x
module tb_upsampler_interp_100x;
`ifdef UPSAMPLER_LINEAR_INTERP_EN
  localparam bit LIN = 1'b1;
`else
  localparam bit LIN = 1'b0;
`endif
  logic clk = 0, rstn = 0, s_valid = 0, err_clr = 0;
  logic signed [15:0] s_data = 0;
  logic m_valid, err_early, err_late;
  logic signed [15:0] m_data;
  int total = 0, bad = 0, cyc = 0;
  int se[0:9];
  logic signed [15:0] hist[0:4095];
  logic vh[0:4095];
  typedef struct {string nm; int seg; int k; int lin; int zoh;} vec_t;
  vec_t tv[16];

  upsampler_interp_100x dut (
    .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_data(s_data), .err_clr(err_clr),
    .m_valid(m_valid), .m_data(m_data), .err_early(err_early), .err_late(err_late)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (cyc < 4096) begin
      hist[cyc] = m_data;
      vh[cyc] = m_valid;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic signed [15:0] d, input int idx);
    s_valid = 1;
    s_data = d;
    tick(1);
    s_valid = 0;
    se[idx] = cyc;
  endtask

  initial begin
    tv[0]  = '{"s1_k0", 1, 0, 0, 0};
    tv[1]  = '{"s1_k1", 1, 1, 10, 0};
    tv[2]  = '{"s1_k50", 1, 50, 500, 0};
    tv[3]  = '{"s1_k99", 1, 99, 989, 0};
    tv[4]  = '{"s2_k0", 2, 0, 1000, 1000};
    tv[5]  = '{"s2_k50", 2, 50, 1000, 1000};
    tv[6]  = '{"desc_k0", 3, 0, 1000, 1000};
    tv[7]  = '{"desc_k50", 3, 50, 500, 1000};
    tv[8]  = '{"desc_k99", 3, 99, 11, 1000};
    tv[9]  = '{"s4_k20", 4, 20, 400, 0};
    tv[10] = '{"early_k0", 5, 0, 2000, 2000};
    tv[11] = '{"early_k10", 5, 10, 1850, 2000};
    tv[12] = '{"s6_k99", 6, 99, 698, 500};
    tv[13] = '{"hold_curr", 6, 100, 700, 700};
    tv[14] = '{"resume_k0", 7, 0, 700, 700};
    tv[15] = '{"resume_k50", 7, 50, 400, 700};
    tick(3);
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_m_data", int'(m_data), 0);
    chk("rst_err_early", int'(err_early), 0);
    chk("rst_err_late", int'(err_late), 0);
    rstn = 1;
    tick(2);
    strobe(0, 0);
    tick(99);
    strobe(1000, 1);
    tick(99);
    strobe(1000, 2);
    tick(99);
    strobe(0, 3);
    tick(99);
    strobe(2000, 4);
    chk("ontime_no_early", int'(err_early), 0);
    chk("ontime_no_late", int'(err_late), 0);
    chk("mv_s1_plus1", int'(vh[se[1]+1]), 0);
    chk("mv_s1_plus2", int'(vh[se[1]+2]), 1);
    tick(40);
    strobe(500, 5);
    chk("early_set", int'(err_early), 1);
    chk("early_no_late", int'(err_late), 0);
    tick(10);
    err_clr = 1;
    tick(1);
    err_clr = 0;
    chk("clr_alone_1", int'(err_early), 0);
    s_valid = 1;
    s_data = 700;
    err_clr = 1;
    tick(1);
    s_valid = 0;
    err_clr = 0;
    se[6] = cyc;
    chk("clr_vs_set", int'(err_early), 1);
    err_clr = 1;
    tick(1);
    err_clr = 0;
    chk("clr_alone_2", int'(err_early), 0);
    tick(110);
    chk("late_set", int'(err_late), 1);
    chk("hold_m_data", int'(m_data), 700);
    chk("hold_m_valid", int'(m_valid), 1);
    chk("hold_no_early", int'(err_early), 0);
    strobe(100, 7);
    chk("resume_no_early", int'(err_early), 0);
    tick(60);
    rstn = 0;
    #1;
    chk("mid_rst_m_valid", int'(m_valid), 0);
    chk("mid_rst_m_data", int'(m_data), 0);
    chk("mid_rst_err_late", int'(err_late), 0);
    tick(2);
    rstn = 1;
    tick(2);
    strobe(300, 8);
    tick(99);
    strobe(300, 9);
    tick(3);
    chk("rerun_mv_idle", int'(vh[se[8]+50]), 0);
    chk("rerun_mv_plus1", int'(vh[se[9]+1]), 0);
    chk("rerun_mv_plus2", int'(vh[se[9]+2]), 1);
    for (int i = 0; i < 16; i++)
      chk(tv[i].nm, int'(hist[se[tv[i].seg]+tv[i].k+2]), LIN ? tv[i].lin : tv[i].zoh);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
